frame_sample_tx: RTL and testbench
==================================

Name: frame_sample_tx

Overview:
Transmit side of the frame sample interface. Holds one frame of N_SAMPLES signed samples in an internal buffer, loaded through a simple write port. On a go pulse it emits a one-cycle frame-start pulse, then streams the frame in index order on out_valid/sample_out. This is the source that drives the start/in_valid/sample_in inputs of the frame analysis blocks (peak detector, etc.) in test and loopback paths.

Parameters:
WIDTH, 16, sample width in bits (two's complement)
N_SAMPLES, 1024, samples per frame; power of two, >= 4
AW, $clog2(N_SAMPLES), derived buffer address width; do not override

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  buffer write strobe
wr_addr  in  AW  buffer write address
wr_data  in  WIDTH  signed sample to write
wr_err  out  1  1-cycle pulse: write rejected because busy
go  in  1  1-cycle pulse: transmit buffered frame
hold  in  1  throttle; stalls streaming
busy  out  1  high from accepted go until done
start_out  out  1  1-cycle frame-start pulse
out_valid  out  1  sample_out valid this cycle
sample_out  out  WIDTH  signed sample
sample_idx  out  AW  index of sample_out
done  out  1  1-cycle pulse after last sample

Behaviour:
- One clock domain; all outputs registered. rst forces all outputs to 0 (sample_out, sample_idx = 0) and the FSM to IDLE. Buffer contents are not cleared by rst.
- Buffer: N_SAMPLES x WIDTH, one write port, one synchronous read port with 1-cycle read latency.
- FSM states: IDLE, PRIME, START, STREAM, DONE.
- IDLE: busy=0. go=1 -> PRIME; read of address 0 issued.
- PRIME: busy=1, no outputs. -> START next cycle.
- START: start_out=1 for exactly this cycle; sample 0 prefetched. -> STREAM.
- STREAM: while registered hold is 0, present one sample per cycle: out_valid=1, sample_out=buf[i], sample_idx=i, for i = 0..N_SAMPLES-1 in order.
- hold high in cycle C forces out_valid=0 in cycle C+1; i does not advance; sample_out/sample_idx hold their last values. No sample is dropped or duplicated across any hold pattern.
- After index N_SAMPLES-1 is presented -> DONE. done=1 for one cycle, busy drops to 0 in the same cycle, then -> IDLE.
- Timing with hold=0: go at T gives start_out at T+2, sample 0 at T+3, last sample at T+2+N_SAMPLES, done at T+3+N_SAMPLES. start_out always precedes the first out_valid by exactly 1 cycle, because downstream arms on start and accepts from the following cycle.
- go while busy=1 is ignored: no restart, no queuing.
- go in the DONE cycle is ignored. Back-to-back frames need go at or after the done cycle + 1.
- wr_en while busy=1: write dropped, wr_err=1 the next cycle.
- wr_en in IDLE: written. A same-cycle wr_en and go in IDLE performs the write first, so the frame includes it.
- wr_addr wraps naturally at AW bits; no range check needed.
- rst asserted mid-frame: immediate abort. out_valid, start_out and done drop asynchronously; no done is issued. After release: IDLE.
- Samples are passed bit-exact; no arithmetic on data.

Decomposition:
- Package frame_tx_pkg: state enum (IDLE, PRIME, START, STREAM, DONE) and the default WIDTH/N_SAMPLES constants. These constants are shared with the frame analysis blocks.
- Sub-module frame_buf_ram: simple dual-port RAM (1 write port, 1 sync-read port, 1-cycle latency), parameterised WIDTH/N_SAMPLES, inferable as block RAM.
- FSM, index counter and hold/prefetch skid register stay in frame_sample_tx.

Test Plan:
(N_SAMPLES=8, WIDTH=16 unless stated)
- Load buf[i]=i*100-300, go at T with hold=0 -> start_out at T+2; out_valid T+3..T+10 carrying -300,-200,...,400 with idx 0..7; done at T+11; busy high T+1..T+10.
- Same load, hold=1 for 3 cycles starting the cycle sample 2 appears -> out_valid low 3 cycles; stream resumes at idx 3; all 8 samples delivered once, in order; done delayed by 3 cycles.
- go pulsed again at sample 4 and wr_en (addr 0, data 0x7FFF) at sample 5 -> no restart; wr_err one cycle after the write; next frame still shows the old buf[0]=-300.
- Extremes: buf = {0x8000, 0x7FFF, 0xFFFF, 0, ...}; drive into a peak detector (WIDTH=16, N_SAMPLES=8) -> peak_out=0x8000, peak_idx=0, out_valid one cycle after the last sample.
- rst pulsed at sample 3 -> all outputs 0, no done. Next go after release -> full clean frame from idx 0 with data retained.
- hold held high from start_out through 5 cycles -> no out_valid during hold; first sample idx 0 appears the cycle after hold falls + 1.

Source files
------------

// File: rtl/frame_tx_pkg.sv
// Shared definitions for the frame sample transmitter and the frame analysis blocks.
package frame_tx_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_N_SAMPLES = 1024;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        START,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/frame_buf_ram.sv
// Frame sample buffer: one write port and one synchronous read port with 1-cycle latency.
// A read and a write to the same address in one cycle return the old contents.
module frame_buf_ram #(
    parameter int WIDTH     = 16,
    parameter int N_SAMPLES = 1024,
    parameter int AW        = $clog2(N_SAMPLES)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [N_SAMPLES];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/frame_sample_tx.sv
// Frame sample transmitter: buffers one frame, then on go emits a start pulse
// followed by the samples in index order, with hold throttling the stream.
import frame_tx_pkg::*;

module frame_sample_tx #(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int N_SAMPLES = DEFAULT_N_SAMPLES,
    parameter int AW        = $clog2(N_SAMPLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_err,
    input  logic             go,
    input  logic             hold,
    output logic             busy,
    output logic             start_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] sample_out,
    output logic [AW-1:0]    sample_idx,
    output logic             done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N_SAMPLES - 1);

    state_t          state, state_next;
    logic [AW-1:0]   cnt, cnt_next;
    logic            last, last_next;
    logic            present;
    logic            wr_ok;
    logic [WIDTH-1:0] rdata;

    // Writes are only safe while no frame is being read out.
    assign wr_ok = (state == IDLE) || (state == DONE);

    // Read address tracks the next index to present, so rdata always holds buf[cnt].
    frame_buf_ram #(
        .WIDTH    (WIDTH),
        .N_SAMPLES(N_SAMPLES),
        .AW       (AW)
    ) u_buf (
        .clk  (clk),
        .we   (wr_en && wr_ok),
        .waddr(wr_addr),
        .wdata(wr_data),
        .raddr(cnt_next),
        .rdata(rdata)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        last_next  = last;
        present    = 1'b0;
        case (state)
            IDLE: begin
                cnt_next  = '0;
                last_next = 1'b0;
                if (go)
                    state_next = PRIME;
            end
            PRIME:  state_next = START;
            START: begin
                state_next = STREAM;
                present    = !hold;
            end
            STREAM: begin
                if (last)
                    state_next = DONE;
                else
                    present = !hold;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (present) begin
            cnt_next = cnt + 1'b1;
            if (cnt == LAST_IDX)
                last_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= 1'b0;
            busy       <= 1'b0;
            start_out  <= 1'b0;
            out_valid  <= 1'b0;
            done       <= 1'b0;
            wr_err     <= 1'b0;
            sample_out <= '0;
            sample_idx <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            last      <= last_next;
            busy      <= (state_next == PRIME) || (state_next == START) || (state_next == STREAM);
            start_out <= (state_next == START);
            done      <= (state_next == DONE);
            out_valid <= present;
            wr_err    <= wr_en && !wr_ok;
            if (present) begin
                sample_out <= rdata;
                sample_idx <= cnt;
            end
        end
    end

endmodule

// File: tb/tb_frame_sample_tx.sv
// Scoreboard bench for frame_sample_tx with an 8-sample frame.
module tb_frame_sample_tx;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic          wr_err;
    logic          go;
    logic          hold;
    logic          busy;
    logic          start_out;
    logic          out_valid;
    logic [W-1:0]  sample_out;
    logic [AW-1:0] sample_idx;
    logic          done;

    frame_sample_tx #(.WIDTH(W), .N_SAMPLES(N), .AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .go(go), .hold(hold), .busy(busy), .start_out(start_out),
        .out_valid(out_valid), .sample_out(sample_out), .sample_idx(sample_idx), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;   // 0 start, 1 sample, 2 done
        logic [W-1:0] data;
        logic [AW-1:0] idx;
    } ev_t;

    ev_t          exp_q[$];
    logic [W-1:0] exp_mem [N];
    int           n_checks = 0;
    int           n_fail   = 0;
    ev_t          mon_e;
    int           mon_k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (start_out || out_valid || done)) begin
            mon_k = start_out ? 0 : (out_valid ? 1 : 2);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: got kind %0d expected none at %0t", mon_k, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("event_kind", mon_k, mon_e.kind);
                if (mon_k == 1) begin
                    chk("sample_data", sample_out, mon_e.data);
                    chk("sample_idx", sample_idx, mon_e.idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input logic [W-1:0] data);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        exp_mem[addr] = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_frame(input int n_samples);
        ev_t e;
        e.kind = 0; e.data = '0; e.idx = '0;
        exp_q.push_back(e);
        for (int i = 0; i < n_samples; i++) begin
            e.kind = 1; e.data = exp_mem[i]; e.idx = AW'(i);
            exp_q.push_back(e);
        end
    endtask

    // Runs one frame from a go pulse; cycle k counts from the go cycle (k=0).
    // hold is high for k in [hk, hk+hl); go2_k re-pulses go, wr_k writes buf[0] while busy.
    task automatic frame(input int hk, input int hl, input int go2_k, input int wr_k, input bit wg);
        ev_t e;
        int  done_k;
        int  sent;
        bit  pv;
        bit  h;
        done_k = 3 + N + hl;
        if (wg) begin
            wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h1234;
            exp_mem[7] = 16'h1234;
        end
        push_frame(N);
        e.kind = 2; e.data = '0; e.idx = '0;
        exp_q.push_back(e);
        go = 1'b1;
        tick();
        go = 1'b0; wr_en = 1'b0;
        sent = 0; pv = 1'b0;
        for (int k = 1; k <= done_k + 1; k++) begin
            chk("start_timing", start_out, 32'(k == 2));
            chk("busy_timing", busy, 32'(k < done_k));
            chk("done_timing", done, 32'(k == done_k));
            chk("valid_timing", out_valid, 32'(pv));
            chk("wr_err_timing", wr_err, 32'(wr_k > 0 && k == wr_k + 1));
            h     = (k >= hk) && (k < hk + hl);
            hold  = h;
            go    = (k == go2_k);
            wr_en = (k == wr_k);
            wr_addr = '0;
            wr_data = 16'h7FFF;
            pv = (k >= 2) && (sent < N) && !h;
            if (pv) sent++;
            tick();
        end
        hold = 1'b0; go = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0; hold = 1'b0;
        tick(); tick();
        chk("reset_outputs", {busy, start_out, out_valid, done, wr_err, sample_out, sample_idx}, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < N; i++) wr(i, W'(i * 100 - 300));
        frame(0, 0, 0, 0, 1'b0);          // plain frame
        frame(5, 3, 0, 0, 1'b0);          // hold over sample 2
        frame(0, 0, 7, 8, 1'b0);          // go and write while busy are rejected
        frame(0, 0, 0, 0, 1'b0);          // buf[0] still -300
        frame(0, 0, 0, 0, 1'b1);          // write with go lands in this frame

        wr(0, 16'h8000); wr(1, 16'h7FFF); wr(2, 16'hFFFF); wr(3, 16'h0000);
        wr(4, 16'h0001); wr(5, 16'hFFFE); wr(6, 16'h4000); wr(7, 16'hC000);
        frame(0, 0, 0, 0, 1'b0);

        // Abort mid-frame: sample 3 would be visible at k=6.
        push_frame(3);
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("abort_outputs", {busy, start_out, out_valid, done, wr_err, sample_out, sample_idx}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        repeat (16) tick();
        chk("abort_no_done", exp_q.size(), 0);
        frame(0, 0, 0, 0, 1'b0);          // clean frame, data retained

        frame(2, 5, 0, 0, 1'b0);          // hold from start_out for 5 cycles

        repeat (4) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
